dcp_status_printer: RTL and testbench

- Parametrised datapath-status printer for the serial debug unit.
- On a start pulse it snapshots NUM_CH data words and streams one ASCII line over the UART TX byte handshake.
- Line format: "LBL=HHHH.. LBL=HHHH..\r\n".
- Successor to the fixed-field status printer: configurable channel count, word width and labels, per-channel enable mask, and a busy/done handshake.

---
 rtl/dcp_pkg.sv | 34 +++
 rtl/dcp_tx_byte_reg.sv | 43 ++++
 rtl/dcp_status_printer.sv | 209 ++++++++++++++++++++
 tb/tb_dcp_status_printer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcp_pkg.sv
// Shared types and helpers for the datapath-status printer.
package dcp_pkg;

  localparam logic [7:0] AsciiEq = 8'h3D;
  localparam logic [7:0] AsciiSp = 8'h20;
  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;

  typedef enum logic [2:0] {
    StIdle,
    StLabel,
    StEq,
    StHex,
    StSep,
    StEol,
    StDone
  } dcp_state_e;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Lowest set mask bit at or above 'from'; 16 means none.
  function automatic logic [4:0] next_set_bit(input logic [15:0] mask, input logic [4:0] from);
    logic [4:0] res;
    res = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if ((5'(i) >= from) && mask[i]) res = 5'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/dcp_tx_byte_reg.sv
// Byte holding register for the TX handshake: contents change only on a load,
// so a stalled byte stays put until the sink takes it.
module dcp_tx_byte_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       load_vld,
  input  logic [7:0] load_byte,
  input  logic       rdy_tx,
  output logic       vld_tx,
  output logic [7:0] d_tx,
  output logic       xfer
);

  logic       vld_q, vld_d;
  logic [7:0] byte_q, byte_d;

  // Next contents: replace on load, otherwise hold.
  always_comb begin
    vld_d  = vld_q;
    byte_d = byte_q;
    if (load) begin
      vld_d  = load_vld;
      byte_d = load_byte;
    end
  end

  // Holding register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      vld_q  <= vld_d;
      byte_q <= byte_d;
    end
  end

  assign vld_tx = vld_q;
  assign d_tx   = byte_q;
  assign xfer   = vld_q & rdy_tx;

endmodule

// File: rtl/dcp_status_printer.sv
// Datapath-status printer: snapshots NUM_CH words on start and streams
// "LBL=HHHH LBL=HHHH\r\n" over a valid/ready byte interface.
// Optional macro DCP_STATUS_LZS_EN suppresses leading zero nibbles per channel.
// The position registers describe the byte currently held in the TX register;
// on each load the successor position is computed and its byte rendered.
module dcp_status_printer
  import dcp_pkg::*;
#(
  parameter int unsigned          NUM_CH = 9,
  parameter int unsigned          DATA_W = 32,
  parameter logic [NUM_CH*32-1:0] LABELS = {NUM_CH{32'h20202020}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic                     busy,
  output logic                     done,
  input  logic                     rdy_tx,
  output logic                     vld_tx,
  output logic [7:0]               d_tx
);

  localparam int unsigned NDIG  = DATA_W / 4;
  localparam int unsigned NIB_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef struct packed {
    dcp_state_e       st;
    logic [4:0]       ch;
    logic [2:0]       lbl;  // label char index; in EOL bit 0 selects LF
    logic [NIB_W-1:0] nib;
  } pos_t;

  localparam pos_t PosRst = '{st: StIdle, ch: 5'd0, lbl: 3'd0, nib: '0};

  pos_t                     pos_q, pos_d;
  logic [NUM_CH*DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic                     load, load_vld, xfer;
  logic [7:0]               load_byte;
  logic [2:0]               nxt_lbl;
  logic [4:0]               nxt_ch;

  function automatic logic [7:0] lbl_char(input logic [4:0] c, input logic [1:0] k);
    logic [31:0] f;
    logic [4:0]  sh;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (5'(i) == c) f = LABELS[i*32 +: 32];
    end
    sh = 5'd24 - {k, 3'b000};
    return f[sh +: 8];
  endfunction

  // First non-NUL label char at or after 'from'; 4 means none left.
  function automatic logic [2:0] first_lbl(input logic [4:0] c, input logic [2:0] from);
    logic [2:0] res;
    res = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if ((3'(k) >= from) && (lbl_char(c, 2'(k)) != 8'h00)) res = 3'(k);
    end
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input logic [NUM_CH*DATA_W-1:0] d,
                                                input logic [4:0] c);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (5'(i) == c) w = d[i*DATA_W +: DATA_W];
    end
    return w;
  endfunction

  // Index of the first digit printed for a word.
  function automatic logic [NIB_W-1:0] first_nib(input logic [DATA_W-1:0] w);
    logic [NIB_W-1:0] res;
`ifdef DCP_STATUS_LZS_EN
    res = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (w[i*4 +: 4] != 4'h0) res = NIB_W'(i);
    end
`else
    res = NIB_W'(NDIG - 1);
    if (w == '0) res = NIB_W'(NDIG - 1);  // word unused without suppression
`endif
    return res;
  endfunction

  // Position of the first byte of channel c (c == 16 means no channel left).
  function automatic pos_t enter(input logic [4:0] c);
    pos_t p;
    p    = PosRst;
    p.ch = c;
    if (c[4]) begin
      p.st = StEol;
    end else begin
      p.lbl = first_lbl(c, 3'd0);
      p.st  = p.lbl[2] ? StEq : StLabel;
    end
    return p;
  endfunction

  function automatic logic [7:0] render(input pos_t p, input logic [NUM_CH*DATA_W-1:0] d);
    logic [7:0] b;
    unique case (p.st)
      StLabel: b = lbl_char(p.ch, p.lbl[1:0]);
      StEq:    b = AsciiEq;
      StHex:   b = hex_to_ascii(4'(word_of(d, p.ch) >> {p.nib, 2'b00}));
      StSep:   b = AsciiSp;
      StEol:   b = p.lbl[0] ? AsciiLf : AsciiCr;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Sequencer: accept start in idle, advance one position per transferred byte.
  always_comb begin
    pos_d    = pos_q;
    data_d   = data_q;
    mask_d   = mask_q;
    load     = 1'b0;
    load_vld = 1'b1;
    nxt_lbl  = 3'd0;
    nxt_ch   = 5'd0;
    unique case (pos_q.st)
      StIdle: begin
        if (start) begin
          load   = 1'b1;
          data_d = data_in;
          mask_d = ch_mask;
          pos_d  = enter(next_set_bit(16'(ch_mask), 5'd0));
        end
      end
      StDone: pos_d.st = StIdle;
      default: begin
        if (xfer) begin
          load = 1'b1;
          unique case (pos_q.st)
            StLabel: begin
              nxt_lbl = first_lbl(pos_q.ch, pos_q.lbl + 3'd1);
              if (nxt_lbl[2]) pos_d.st = StEq;
              else            pos_d.lbl = nxt_lbl;
            end
            StEq: begin
              pos_d.st  = StHex;
              pos_d.nib = first_nib(word_of(data_q, pos_q.ch));
            end
            StHex: begin
              if (pos_q.nib != '0) begin
                pos_d.nib = pos_q.nib - 1'b1;
              end else begin
                nxt_ch = next_set_bit(16'(mask_q), pos_q.ch + 5'd1);
                if (nxt_ch[4]) begin
                  pos_d.st  = StEol;
                  pos_d.lbl = 3'd0;
                end else begin
                  pos_d.st = StSep;
                  pos_d.ch = nxt_ch;
                end
              end
            end
            StSep: pos_d = enter(pos_q.ch);
            StEol: begin
              if (!pos_q.lbl[0]) begin
                pos_d.lbl = 3'd1;
              end else begin
                pos_d.st = StDone;
                load_vld = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    load_byte = render(pos_d, data_d);
  end

  // Position and snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= PosRst;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      pos_q  <= pos_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  dcp_tx_byte_reg u_tx_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_vld  (load_vld),
    .load_byte (load_byte),
    .rdy_tx    (rdy_tx),
    .vld_tx    (vld_tx),
    .d_tx      (d_tx),
    .xfer      (xfer)
  );

  assign busy = (pos_q.st != StIdle) && (pos_q.st != StDone);
  assign done = (pos_q.st == StDone);

endmodule

// File: tb/tb_dcp_status_printer.sv
// Directed bench for dcp_status_printer (2 channels "PC"/"IR", 32-bit words).
// Expected lines follow DCP_STATUS_LZS_EN when it is defined.
module tb_dcp_status_printer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rdy_tx = 1'b1;
  logic [63:0] data_in = '0;
  logic [1:0]  ch_mask = '0;
  logic        busy, done, vld_tx;
  logic [7:0]  d_tx;

  int tests = 0;
  int fails = 0;

  byte unsigned q[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          stall_err = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_d = '0;
  bit          ok;

`ifdef DCP_STATUS_LZS_EN
  localparam string ExpL1   = "PC=1234 IR=DEADBEEF\r\n";
  localparam string ExpMid  = "PC=ABCD IR=12345678\r\n";
  localparam string ExpRst  = "PC=CAFE0001 IR=10\r\n";
  localparam string ExpZero = "PC=1234 IR=0\r\n";
  localparam string ExpOne  = "PC=0\r\n";
`else
  localparam string ExpL1   = "PC=00001234 IR=DEADBEEF\r\n";
  localparam string ExpMid  = "PC=0000ABCD IR=12345678\r\n";
  localparam string ExpRst  = "PC=CAFE0001 IR=00000010\r\n";
  localparam string ExpZero = "PC=00001234 IR=00000000\r\n";
  localparam string ExpOne  = "PC=00000000\r\n";
`endif
  localparam string ExpIr = "IR=DEADBEEF\r\n";
  localparam string ExpNl = "\r\n";

  always #5 clk = ~clk;

  dcp_status_printer #(
    .NUM_CH (2),
    .DATA_W (32),
    .LABELS ({32'h49520000, 32'h50430000})
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .ch_mask (ch_mask),
    .busy    (busy),
    .done    (done),
    .rdy_tx  (rdy_tx),
    .vld_tx  (vld_tx),
    .d_tx    (d_tx)
  );

  // Mid-cycle monitor: records transfers due at the next edge and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!vld_tx || d_tx !== prev_d)) stall_err++;
      if (vld_tx && rdy_tx) q.push_back(d_tx);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      prev_stall = vld_tx && !rdy_tx;
      prev_d     = d_tx;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  function automatic string q2s();
    string s = "";
    foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
    return s;
  endfunction

  task automatic chk_s(input string tag, input string obs, input string exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, vis(obs), vis(exp));
    end
  endtask

  task automatic start_line(input logic [63:0] d, input logic [1:0] m);
    @(posedge clk); #1;
    data_in = d;
    ch_mask = m;
    start   = 1'b1;
    q.delete();
    done_cnt  = 0;
    busy_cnt  = 0;
    stall_err = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run until done is seen (left in the done cycle) or the budget expires.
  task automatic wait_done(input int max, input bit rnd, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      rdy_tx = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      @(posedge clk); #1;
    end
    rdy_tx = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_vld", {63'd0, vld_tx}, 64'd0);
    chk("rst_d_tx", {56'd0, d_tx}, 64'd0);
    rst = 1'b0;

    // Full line, sink always ready; first byte one cycle after start
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b11);
    chk("latency_vld", {63'd0, vld_tx}, 64'd1);
    chk("latency_byte", {56'd0, d_tx}, 64'h50);
    wait_done(200, 1'b0, ok);
    chk("l1_done_seen", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    chk_s("l1_line", q2s(), ExpL1);
    chk("l1_busy_cycles", 64'(busy_cnt), 64'(ExpL1.len()));
    chk("l1_done_cnt", 64'(done_cnt), 64'd1);

    // Same line with a stalling sink
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b11);
    wait_done(400, 1'b1, ok);
    chk("stall_done_seen", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    chk_s("stall_line", q2s(), ExpL1);
    chk("stall_stable", 64'(stall_err), 64'd0);
    chk("stall_done_cnt", 64'(done_cnt), 64'd1);

    // Channel 0 masked off
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b10);
    wait_done(200, 1'b0, ok);
    @(posedge clk); #1;
    chk_s("mask10_line", q2s(), ExpIr);
    chk("mask10_busy_cycles", 64'(busy_cnt), 64'd13);

    // No channels enabled
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b00);
    wait_done(200, 1'b0, ok);
    chk("mask00_done_seen", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    chk_s("mask00_line", q2s(), ExpNl);
    chk("mask00_busy_cycles", 64'(busy_cnt), 64'd2);

    // Start and data change while busy (5th byte presented)
    start_line({32'h12345678, 32'h0000ABCD}, 2'b11);
    repeat (4) @(posedge clk);
    #1;
    start   = 1'b1;
    data_in = '1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, 1'b0, ok);
    repeat (6) @(posedge clk);
    #1;
    chk_s("mid_start_line", q2s(), ExpMid);
    chk("mid_start_done_cnt", 64'(done_cnt), 64'd1);
    chk("mid_start_idle", {63'd0, busy}, 64'd0);

    // Reset after the 7th byte
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b11);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_vld", {63'd0, vld_tx}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_d_tx", {56'd0, d_tx}, 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    start_line({32'h00000010, 32'hCAFE0001}, 2'b11);
    wait_done(200, 1'b0, ok);
    @(posedge clk); #1;
    chk_s("after_rst_line", q2s(), ExpRst);

    // Zero word
    start_line({32'h00000000, 32'h00001234}, 2'b11);
    wait_done(200, 1'b0, ok);
    @(posedge clk); #1;
    chk_s("zero_line", q2s(), ExpZero);

    // Start held through the done cycle: ignored there, accepted in the idle cycle
    start_line({32'hDEADBEEF, 32'h00001234}, 2'b11);
    wait_done(200, 1'b0, ok);
    chk("dn_done_now", {63'd0, done}, 64'd1);
    start   = 1'b1;
    data_in = {32'h0000000F, 32'h00000000};
    ch_mask = 2'b01;
    @(posedge clk); #1;
    chk("dn_ignored_busy", {63'd0, busy}, 64'd0);
    chk("dn_ignored_vld", {63'd0, vld_tx}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_accept_busy", {63'd0, busy}, 64'd1);
    q.delete();
    done_cnt = 0;
    wait_done(200, 1'b0, ok);
    @(posedge clk); #1;
    chk_s("idle_accept_line", q2s(), ExpOne);
    chk("idle_accept_done_cnt", 64'(done_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
